// File: rtl/ln40x7_prog_seq_pkg.sv
// Shared definitions for the programmable Johnson sequencer family: state encoding,
// legality test, modulus clamp and the next-state source selector.
package ln40x7_prog_seq_pkg;

    localparam int MAX_STAGES = 16;

    typedef logic [MAX_STAGES-1:0] jvec_t;

    typedef enum logic [1:0] {
        SEL_LOCKOUT,
        SEL_HOLD,
        SEL_SHIFT,
        SEL_LOAD
    } next_sel_e;

    // State k fills k ones from the bottom; past n the ones drain from the bottom.
    function automatic jvec_t johnson_encode(input int k, input int n);
        jvec_t ones;
        jvec_t r;
        ones = '0;
        r    = '0;
        for (int b = 0; b < MAX_STAGES; b++) begin
            if (b < n) ones[b] = 1'b1;
        end
        if (k <= n) begin
            for (int b = 0; b < MAX_STAGES; b++) begin
                if (b < k) r[b] = 1'b1;
            end
        end else begin
            r = (ones << (k - n)) & ones;
        end
        return r;
    endfunction

    function automatic logic johnson_valid(input jvec_t j, input int n);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * MAX_STAGES; k++) begin
            if (k < 2 * n && j == johnson_encode(k, n)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic int effective_modulus(input int len_val, input int nout);
        return (len_val < 2 || len_val > nout) ? nout : len_val;
    endfunction

endpackage

// File: rtl/ln40x7_prog_seq_if.sv
// Control and decoded-output bundle of one sequencer stage.
interface ln40x7_prog_seq_if #(parameter int NSTAGES = 5);

    localparam int NOUT = 2 * NSTAGES;
    localparam int LW   = $clog2(NOUT + 1);

    logic            cp1;
    logic            dir;
    logic [LW-1:0]   len;
    logic [NOUT-1:0] out_q;
    logic            q59_n;
    logic [LW-1:0]   idx;
    logic            tc;
    logic            err;

    modport master (
        output cp1, dir, len,
        input  out_q, q59_n, idx, tc, err
    );

    modport slave (
        input  cp1, dir, len,
        output out_q, q59_n, idx, tc, err
    );

endinterface

// File: rtl/ln40x7_prog_seq_decode.sv
// Combinational Johnson decoder: one-hot outputs, binary index, carry and legality flag.
module ln_johnson_decode
    import ln40x7_prog_seq_pkg::*;
#(
    parameter int NSTAGES = 5
) (
    input  logic [NSTAGES-1:0]                     j,
    output logic [2*NSTAGES-1:0]                   out_q,
    output logic [$clog2(2*NSTAGES+1)-1:0]         idx,
    output logic                                   q59_n,
    output logic                                   err
);

    localparam int NOUT = 2 * NSTAGES;
    localparam int LW   = $clog2(NOUT + 1);

    logic [LW-1:0] ones_cnt;

    assign out_q[0]       = ~j[NSTAGES-1] & ~j[0];
    assign out_q[NSTAGES] =  j[NSTAGES-1] &  j[0];

    for (genvar k = 1; k < NSTAGES; k++) begin : g_fill
        assign out_q[k] = j[k-1] & ~j[k];
    end

    for (genvar k = NSTAGES + 1; k < NOUT; k++) begin : g_drain
        assign out_q[k] = ~j[k-NSTAGES-1] & j[k-NSTAGES];
    end

    assign q59_n = ~j[NSTAGES-1];
    assign err   = ~johnson_valid(jvec_t'(j), NSTAGES);

    // Filling states are identified by j[0]=1 (or all zero); draining states count down from NOUT.
    always_comb begin
        ones_cnt = '0;
        for (int b = 0; b < NSTAGES; b++) begin
            ones_cnt = ones_cnt + LW'(j[b]);
        end
        if (j[0] || ones_cnt == '0) begin
            idx = ones_cnt;
        end else begin
            idx = LW'(NOUT) - ones_cnt;
        end
    end

endmodule

// File: rtl/ln40x7_prog_seq.sv
// Programmable-modulus up/down Johnson sequencer with terminal count and illegal-state recovery.
module ln40x7_prog_seq
    import ln40x7_prog_seq_pkg::*;
#(
    parameter int NSTAGES = 5
) (
    input  logic              cp0,
    input  logic              mr,
    ln40x7_prog_seq_if.slave  bus
);

    localparam int NOUT = 2 * NSTAGES;
    localparam int LW   = $clog2(NOUT + 1);

    logic [NSTAGES-1:0] j_q;
    logic [NSTAGES-1:0] j_next;
    logic [NSTAGES-1:0] shift_j;
    logic [NOUT-1:0]    out_q;
    logic [LW-1:0]      idx;
    logic               q59_n;
    logic               err;
    int                 m;
    int                 idx_i;
    int                 target;
    next_sel_e          sel;

    ln_johnson_decode #(.NSTAGES(NSTAGES)) u_decode (
        .j     (j_q),
        .out_q (out_q),
        .idx   (idx),
        .q59_n (q59_n),
        .err   (err)
    );

    if (NSTAGES == 1) begin : g_shift_one
        assign shift_j = ~j_q;
    end else begin : g_shift_n
        assign shift_j = {j_q[NSTAGES-2:0], ~j_q[NSTAGES-1]};
    end

    always_ff @(posedge cp0) begin
        if (mr) begin
            j_q <= '0;
        end else begin
            j_q <= j_next;
        end
    end

    // Wraps, reversals and short moduli jump by loading the encoded target; a full-length
    // up count is just the natural Johnson rotation.
    always_comb begin
        m      = effective_modulus(int'(bus.len), NOUT);
        idx_i  = int'(idx);
        target = 0;
        sel    = SEL_HOLD;
        j_next = j_q;

        if (bus.dir) begin
            target = (idx_i == 0 || idx_i > m - 1) ? m - 1 : idx_i - 1;
        end else begin
            target = (idx_i >= m - 1) ? 0 : idx_i + 1;
        end

        if (err) begin
            sel = SEL_LOCKOUT;
        end else if (bus.cp1) begin
            sel = SEL_HOLD;
        end else if (!bus.dir && m == NOUT) begin
            sel = SEL_SHIFT;
        end else begin
            sel = SEL_LOAD;
        end

        case (sel)
            SEL_LOCKOUT: j_next = '0;
            SEL_HOLD:    j_next = j_q;
            SEL_SHIFT:   j_next = shift_j;
            SEL_LOAD:    j_next = NSTAGES'(johnson_encode(target, NSTAGES));
            default:     j_next = '0;
        endcase
    end

    always_comb begin
        bus.tc = 1'b0;
        if (!bus.cp1 && !err) begin
            bus.tc = bus.dir ? (idx_i == 0) : (idx_i == m - 1);
        end
    end

    assign bus.out_q = out_q;
    assign bus.idx   = idx;
    assign bus.q59_n = q59_n;
    assign bus.err   = err;

endmodule

// File: tb/tb_ln40x7_prog_seq.sv
// Bench for ln40x7_prog_seq: directed walk plus random run on a 5-stage unit, a cascaded pair,
// and a randomly driven sweep over 1..8 stages, all against an index-level model.
module tb_ln40x7_prog_seq;

    logic       cp0 = 1'b0;
    logic       mr;
    logic       sw_mr;
    logic       sw_cp1;
    logic       sw_dir;
    logic [4:0] sw_len;

    int  nvec      = 0;
    int  nmis      = 0;
    int  cyc       = 0;
    int  pin_idx   = -1;
    int  pin_tc    = -1;
    bit  pin_casc  = 1'b0;
    bit  force_req = 1'b0;
    bit  chk_en    = 1'b0;
    bit  sw_live   = 1'b0;

    int  m_idx = 0;
    int  a_idx = 0;
    int  b_idx = 0;
    int  s_idx [1:8];

    logic [4:0]  sw_idx  [1:8];
    logic [15:0] sw_outq [1:8];
    logic        sw_tc   [1:8];
    logic        sw_q59  [1:8];
    logic        sw_err  [1:8];

    always #5 cp0 = ~cp0;

    ln40x7_prog_seq_if #(.NSTAGES(5)) bus ();
    ln40x7_prog_seq #(.NSTAGES(5)) dut (.cp0(cp0), .mr(mr), .bus(bus));

    // Cascade: B only advances while A sits at its terminal count.
    ln40x7_prog_seq_if #(.NSTAGES(5)) ca_bus ();
    ln40x7_prog_seq_if #(.NSTAGES(5)) cb_bus ();
    assign ca_bus.cp1 = 1'b0;
    assign ca_bus.dir = 1'b0;
    assign ca_bus.len = 4'd10;
    assign cb_bus.cp1 = ~ca_bus.tc;
    assign cb_bus.dir = 1'b0;
    assign cb_bus.len = 4'd10;
    ln40x7_prog_seq #(.NSTAGES(5)) u_casc_a (.cp0(cp0), .mr(mr), .bus(ca_bus));
    ln40x7_prog_seq #(.NSTAGES(5)) u_casc_b (.cp0(cp0), .mr(mr), .bus(cb_bus));

    for (genvar g = 1; g <= 8; g++) begin : g_sweep
        localparam int SLW = $clog2(2 * g + 1);
        ln40x7_prog_seq_if #(.NSTAGES(g)) sif ();
        assign sif.cp1 = sw_cp1;
        assign sif.dir = sw_dir;
        assign sif.len = sw_len[SLW-1:0];
        ln40x7_prog_seq #(.NSTAGES(g)) u_dut (.cp0(cp0), .mr(sw_mr), .bus(sif));
        assign sw_idx[g]  = 5'(sif.idx);
        assign sw_outq[g] = 16'(sif.out_q);
        assign sw_tc[g]   = sif.tc;
        assign sw_q59[g]  = sif.q59_n;
        assign sw_err[g]  = sif.err;
    end

    function automatic int eff_mod(input int l, input int nout);
        return (l < 2 || l > nout) ? nout : l;
    endfunction

    function automatic int next_idx(input int i, input int m, input bit down);
        if (down) return (i == 0 || i > m - 1) ? m - 1 : i - 1;
        return (i >= m - 1) ? 0 : i + 1;
    endfunction

    function automatic int sw_len_for(input int n, input logic [4:0] l);
        int w;
        w = $clog2(2 * n + 1);
        return int'(l) % (1 << w);
    endfunction

    // Reference model: a plain modulo counter per unit.
    always @(posedge cp0) begin
        if (mr || force_req) m_idx <= 0;
        else if (!bus.cp1) m_idx <= next_idx(m_idx, eff_mod(int'(bus.len), 10), bus.dir);
        if (mr) begin
            a_idx <= 0;
            b_idx <= 0;
        end else begin
            a_idx <= (a_idx + 1) % 10;
            if (a_idx == 9) b_idx <= (b_idx + 1) % 10;
        end
        for (int n = 1; n <= 8; n++) begin
            if (sw_mr) s_idx[n] <= 0;
            else if (!sw_cp1)
                s_idx[n] <= next_idx(s_idx[n], eff_mod(sw_len_for(n, sw_len), 2 * n), sw_dir);
        end
    end

    task automatic check_output(input string nm, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    always @(negedge cp0) begin
        #3;
        cyc++;
        if (chk_en) begin
            if (force_req) begin
                check_output("lock_err", longint'(bus.err), 1);
                check_output("lock_tc", longint'(bus.tc), 0);
                check_output("lock_q59_n", longint'(bus.q59_n), 1);
            end else begin
                check_output("idx", longint'(bus.idx), m_idx);
                check_output("out_q", longint'(bus.out_q), longint'(1) << m_idx);
                check_output("q59_n", longint'(bus.q59_n), longint'(m_idx < 5));
                check_output("tc", longint'(bus.tc), longint'(!bus.cp1 && (bus.dir ? m_idx == 0
                             : m_idx == eff_mod(int'(bus.len), 10) - 1)));
                check_output("err", longint'(bus.err), 0);
            end
            if (pin_idx >= 0) begin
                check_output("pin_dut_idx", longint'(bus.idx), pin_idx);
                check_output("pin_model_idx", m_idx, pin_idx);
            end
            if (pin_tc >= 0) check_output("pin_tc", longint'(bus.tc), pin_tc);
            if (pin_casc) begin
                check_output("pin_casc_a", longint'(ca_bus.idx), 0);
                check_output("pin_casc_b", longint'(cb_bus.idx), 0);
                check_output("pin_casc_model_b", b_idx, 0);
            end
            check_output("casc_a_idx", longint'(ca_bus.idx), a_idx);
            check_output("casc_b_idx", longint'(cb_bus.idx), b_idx);
            check_output("casc_a_tc", longint'(ca_bus.tc), longint'(a_idx == 9));
            check_output("casc_b_tc", longint'(cb_bus.tc), longint'(a_idx == 9 && b_idx == 9));
            for (int n = 1; n <= 8; n++) begin
                check_output($sformatf("sw%0d_idx", n), longint'(sw_idx[n]), s_idx[n]);
                check_output($sformatf("sw%0d_out_q", n), longint'(sw_outq[n]), longint'(1) << s_idx[n]);
                check_output($sformatf("sw%0d_q59_n", n), longint'(sw_q59[n]), longint'(s_idx[n] < n));
                check_output($sformatf("sw%0d_tc", n), longint'(sw_tc[n]),
                             longint'(!sw_cp1 && (sw_dir ? s_idx[n] == 0
                             : s_idx[n] == eff_mod(sw_len_for(n, sw_len), 2 * n) - 1)));
                check_output($sformatf("sw%0d_err", n), longint'(sw_err[n]), 0);
            end
        end
    end

    task automatic apply_stimulus(input bit m, input bit c, input bit d, input int l,
                                  input int pi, input int pt);
        @(negedge cp0);
        mr        = m;
        bus.cp1   = c;
        bus.dir   = d;
        bus.len   = 4'(l);
        pin_idx   = pi;
        pin_tc    = pt;
        pin_casc  = 1'b0;
        force_req = 1'b0;
        if (sw_live) begin
            sw_mr  = ($urandom_range(0, 29) == 0);
            sw_cp1 = ($urandom_range(0, 3) == 0);
            sw_dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sw_len = 5'($urandom_range(0, 31));
        end else begin
            sw_mr = 1'b1;
        end
    endtask

    task automatic rand_step(input bit allow_mr, inout int rlen);
        if ($urandom_range(0, 5) == 0) rlen = int'($urandom_range(0, 15));
        apply_stimulus(allow_mr && ($urandom_range(0, 39) == 0), $urandom_range(0, 3) == 0,
                       1'($urandom_range(0, 1)), rlen, -1, -1);
    endtask

    task automatic lockout_step(input bit with_mr);
        @(negedge cp0);
        mr        = with_mr;
        bus.cp1   = 1'b1;
        pin_idx   = -1;
        pin_tc    = -1;
        force_req = 1'b1;
        force dut.j_q = 5'b01010;
        #4;
        release dut.j_q;
    endtask

    initial begin
        int rlen;
        int seq4 [9];
        rlen    = 10;
        seq4    = '{0, 6, 5, 4, 3, 2, 1, 0, 6};
        mr      = 1'b1;
        bus.cp1 = 1'b0;
        bus.dir = 1'b0;
        bus.len = 4'd10;
        sw_mr   = 1'b1;
        sw_cp1  = 1'b0;
        sw_dir  = 1'b0;
        sw_len  = 5'd10;

        apply_stimulus(1, 0, 0, 10, -1, -1);
        chk_en  = 1'b1;
        sw_live = 1'b1;
        apply_stimulus(1, 0, 0, 10, 0, 0);

        // Free-running full decade
        for (int i = 0; i < 25; i++) apply_stimulus(0, 0, 0, 10, i % 10, int'(i % 10 == 9));

        // Inhibit hold at idx 3
        apply_stimulus(1, 0, 0, 10, 5, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 10, i, 0);
        for (int i = 0; i < 7; i++) apply_stimulus(0, 1, 0, 10, 3, 0);
        apply_stimulus(0, 0, 0, 10, 3, 0);

        // Modulus 6, shrink to 3 above range, then out-of-range lengths
        apply_stimulus(1, 0, 0, 6, 4, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 0, 6, i % 6, int'(i % 6 == 5));
        for (int i = 2; i < 5; i++) apply_stimulus(0, 0, 0, 6, i, 0);
        apply_stimulus(0, 0, 0, 3, 5, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++)
                apply_stimulus(0, 0, 0, (r == 0) ? 0 : (r == 1) ? 1 : 15, i, int'(i == 9));
        end

        // Down count modulus 7, then reverse mid-run
        apply_stimulus(1, 0, 1, 7, 0, 1);
        for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 1, 7, seq4[i], int'(seq4[i] == 0));
        apply_stimulus(0, 0, 1, 7, 5, 0);
        apply_stimulus(0, 0, 1, 7, 4, 0);
        apply_stimulus(0, 0, 0, 7, 3, 0);
        apply_stimulus(0, 0, 0, 7, 4, 0);

        // Illegal pattern recovery, without and with reset
        lockout_step(1'b0);
        apply_stimulus(0, 1, 0, 10, 0, 0);
        apply_stimulus(0, 0, 0, 10, 0, 0);
        apply_stimulus(0, 0, 0, 10, 1, 0);
        lockout_step(1'b1);
        apply_stimulus(0, 0, 0, 10, 0, 0);

        // Cascade: 100 edges after reset both stages are back at 0
        apply_stimulus(1, 0, 0, 10, -1, -1);
        for (int i = 0; i < 100; i++) rand_step(1'b0, rlen);
        rand_step(1'b0, rlen);
        pin_casc = 1'b1;

        for (int i = 0; i < 300; i++) rand_step(1'b1, rlen);

        @(negedge cp0);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
